// File: rtl/phase_inc_meter.sv
// Phase-increment meter: averages modular deltas of a phase-word stream over a
// power-of-two window and publishes the mean as a frequency word.
module phase_inc_meter #(
  parameter int unsigned PHASE_BITS   = 32,
  parameter int unsigned MAX_WIN_LOG2 = 16,
  parameter int unsigned OUT_BUS_SIZE = 32
) (
  input  logic                               out_clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               sync_i,
  input  logic [PHASE_BITS-1:0]              phase_in,
  input  logic                               phase_valid,
  input  logic [4:0]                         win_log2,
  output logic [OUT_BUS_SIZE-1:0]            inc_out,
  output logic                               inc_valid,
  output logic [PHASE_BITS+MAX_WIN_LOG2-1:0] sum_out,
  output logic                               busy
);

  localparam int unsigned SumW = PHASE_BITS + MAX_WIN_LOG2;
  localparam int unsigned CntW = MAX_WIN_LOG2 + 1;

  typedef enum logic [1:0] {StIdle, StPrime, StAccum} state_e;

  state_e                  state_q, state_d;
  logic [PHASE_BITS-1:0]   prev_q, prev_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [4:0]              wl_q, wl_d;
  // Delta stage
  logic [PHASE_BITS-1:0]   dlt_q, dlt_d;
  logic                    dlt_vld_q, dlt_vld_d;
  logic                    dlt_last_q, dlt_last_d;
  logic [4:0]              dlt_wl_q, dlt_wl_d;
  logic                    clr_q, clr_d;
  // Sum stage
  logic [SumW-1:0]         sum_q, sum_d;
  logic                    fin_vld_q, fin_vld_d;
  logic [SumW-1:0]         fin_sum_q, fin_sum_d;
  logic [4:0]              fin_wl_q, fin_wl_d;
  // Output stage
  logic [OUT_BUS_SIZE-1:0] inc_out_q, inc_out_d;
  logic [SumW-1:0]         sum_out_q, sum_out_d;
  logic                    inc_valid_q, inc_valid_d;

  logic [4:0]            wl_clamp;
  logic [CntW-1:0]       cnt_inc;
  logic [CntW-1:0]       win_n;
  logic [SumW-1:0]       sum_nxt;
  logic [PHASE_BITS-1:0] avg;

  assign wl_clamp = (win_log2 > 5'(MAX_WIN_LOG2)) ? 5'(MAX_WIN_LOG2) : win_log2;
  assign cnt_inc  = cnt_q + CntW'(1);
  assign win_n    = CntW'(1) << wl_q;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    wl_d       = wl_q;
    dlt_d      = dlt_q;
    dlt_vld_d  = 1'b0;
    dlt_last_d = 1'b0;
    dlt_wl_d   = dlt_wl_q;
    clr_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) state_d = StPrime;
      end
      StPrime: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (!sync_i && phase_valid) begin
          prev_d  = phase_in;
          wl_d    = wl_clamp;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (!enable || sync_i) begin
          // Abort: the partial sum is cleared one cycle later in the sum stage.
          state_d = enable ? StPrime : StIdle;
          cnt_d   = '0;
          clr_d   = 1'b1;
        end else if (phase_valid) begin
          dlt_d     = phase_in - prev_q;
          prev_d    = phase_in;
          dlt_vld_d = 1'b1;
          dlt_wl_d  = wl_q;
          if (cnt_inc == win_n) begin
            dlt_last_d = 1'b1;
            cnt_d      = '0;
            wl_d       = wl_clamp;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sum_nxt   = sum_q + SumW'(dlt_q);
    sum_d     = sum_q;
    fin_vld_d = 1'b0;
    fin_sum_d = fin_sum_q;
    fin_wl_d  = fin_wl_q;
    if (clr_q) begin
      sum_d = '0;
    end else if (dlt_vld_q) begin
      if (dlt_last_q) begin
        fin_vld_d = 1'b1;
        fin_sum_d = sum_nxt;
        fin_wl_d  = dlt_wl_q;
        sum_d     = '0;
      end else begin
        sum_d = sum_nxt;
      end
    end
  end

  always_comb begin
    avg         = PHASE_BITS'(fin_sum_q >> fin_wl_q);
    inc_valid_d = fin_vld_q;
    inc_out_d   = inc_out_q;
    sum_out_d   = sum_out_q;
    if (fin_vld_q) begin
      inc_out_d = OUT_BUS_SIZE'(avg);
      sum_out_d = fin_sum_q;
    end
  end

  always_ff @(posedge out_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      prev_q      <= '0;
      cnt_q       <= '0;
      wl_q        <= '0;
      dlt_q       <= '0;
      dlt_vld_q   <= 1'b0;
      dlt_last_q  <= 1'b0;
      dlt_wl_q    <= '0;
      clr_q       <= 1'b0;
      sum_q       <= '0;
      fin_vld_q   <= 1'b0;
      fin_sum_q   <= '0;
      fin_wl_q    <= '0;
      inc_out_q   <= '0;
      sum_out_q   <= '0;
      inc_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      wl_q        <= wl_d;
      dlt_q       <= dlt_d;
      dlt_vld_q   <= dlt_vld_d;
      dlt_last_q  <= dlt_last_d;
      dlt_wl_q    <= dlt_wl_d;
      clr_q       <= clr_d;
      sum_q       <= sum_d;
      fin_vld_q   <= fin_vld_d;
      fin_sum_q   <= fin_sum_d;
      fin_wl_q    <= fin_wl_d;
      inc_out_q   <= inc_out_d;
      sum_out_q   <= sum_out_d;
      inc_valid_q <= inc_valid_d;
    end
  end

  assign inc_out   = inc_out_q;
  assign sum_out   = sum_out_q;
  assign inc_valid = inc_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_phase_inc_meter.sv
// Directed bench for phase_inc_meter: vector table plus hand-written corner sequences.
module tb_phase_inc_meter;

  logic        out_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        sync_i = 1'b0;
  logic [31:0] phase_in = '0;
  logic        phase_valid = 1'b0;
  logic [4:0]  win_log2 = 5'd0;
  logic [31:0] inc_out;
  logic        inc_valid;
  logic [47:0] sum_out;
  logic        busy;

  int n_checks = 0;
  int n_err = 0;

  phase_inc_meter dut (
    .out_clk     (out_clk),
    .rst         (rst),
    .enable      (enable),
    .sync_i      (sync_i),
    .phase_in    (phase_in),
    .phase_valid (phase_valid),
    .win_log2    (win_log2),
    .inc_out     (inc_out),
    .inc_valid   (inc_valid),
    .sum_out     (sum_out),
    .busy        (busy)
  );

  always #5 out_clk = ~out_clk;

  typedef struct {
    logic        en;
    logic        pv;
    logic [31:0] ph;
    logic [4:0]  wl;
    logic        vld;
    logic [31:0] inc;
    logic [47:0] sum;
    logic        bsy;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic en, input logic sy, input logic pv, input logic [31:0] ph,
                      input logic [4:0] wl);
    enable      = en;
    sync_i      = sy;
    phase_valid = pv;
    phase_in    = ph;
    win_log2    = wl;
    @(posedge out_clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32'h0000_0000, 5'd2, 1'b0, 32'h0, 48'h0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 32'h0000_0000, 5'd2, 1'b0, 32'h0, 48'h0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 32'h0100_0000, 5'd2, 1'b0, 32'h0, 48'h0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 32'h0200_0000, 5'd2, 1'b0, 32'h0, 48'h0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 32'h0300_0000, 5'd2, 1'b0, 32'h0, 48'h0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 32'h0400_0000, 5'd2, 1'b0, 32'h0, 48'h0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 32'h0500_0000, 5'd2, 1'b0, 32'h0, 48'h0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 32'h0600_0000, 5'd2, 1'b1, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 32'h0700_0000, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 32'h0800_0000, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'h0900_0000, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 32'h0A00_0000, 5'd2, 1'b1, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h0000_0000, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 32'h0000_0000, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 32'h0000_0064, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 32'h0000_0065, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 32'h0000_0067, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[17] = '{1'b1, 1'b1, 32'h0000_0069, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[18] = '{1'b1, 1'b1, 32'h0000_006B, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 32'h0000_0000, 5'd2, 1'b0, 32'h0100_0000, 48'h0400_0000, 1'b1};
    tbl[20] = '{1'b1, 1'b0, 32'h0000_0000, 5'd2, 1'b1, 32'h0000_0001, 48'h7, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 32'h0000_0000, 5'd2, 1'b0, 32'h0000_0001, 48'h7, 1'b1};

    // Reset state
    repeat (2) @(posedge out_clk);
    #1;
    chk("rst_inc_out", 64'(inc_out), 64'h0);
    chk("rst_sum_out", 64'(sum_out), 64'h0);
    chk("rst_inc_valid", 64'(inc_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;

    // Constant increment, enable drop, truncating average
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].en, 1'b0, tbl[i].pv, tbl[i].ph, tbl[i].wl);
      chk($sformatf("tbl%0d_vld", i), 64'(inc_valid), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d_inc", i), 64'(inc_out), 64'(tbl[i].inc));
      chk($sformatf("tbl%0d_sum", i), 64'(sum_out), 64'(tbl[i].sum));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].bsy));
    end

    // Wrap-around with win_log2=0: one output per delta
    step(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] ph;
      ph = 32'(k) * 32'h9000_0000;
      step(1'b1, 1'b0, (k <= 5), ph, 5'd0);
      chk($sformatf("wrap%0d_vld", k), 64'(inc_valid), 64'((k >= 3) ? 1 : 0));
      if (k >= 3) begin
        chk($sformatf("wrap%0d_inc", k), 64'(inc_out), 64'h9000_0000);
        chk($sformatf("wrap%0d_sum", k), 64'(sum_out), 64'h9000_0000);
      end
    end

    // sync_i aborts a window after 5 of 8 deltas
    step(1'b0, 1'b0, 1'b0, 32'h0, 5'd3);
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'd3);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b0, 1'b1, 32'(k) * 32'h10, 5'd3);
      chk($sformatf("pre_sync%0d_vld", k), 64'(inc_valid), 64'h0);
    end
    step(1'b1, 1'b1, 1'b1, 32'hDEAD_0000, 5'd3);
    chk("sync_vld", 64'(inc_valid), 64'h0);
    chk("sync_busy", 64'(busy), 64'h1);
    chk("sync_hold_inc", 64'(inc_out), 64'h9000_0000);
    for (int j = 0; j < 9; j++) begin
      step(1'b1, 1'b0, 1'b1, 32'h1234 + 32'(j) * 32'h10, 5'd3);
      chk($sformatf("post_sync%0d_vld", j), 64'(inc_valid), 64'h0);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'd3);
    chk("sync_lat1_vld", 64'(inc_valid), 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'd3);
    chk("sync_out_vld", 64'(inc_valid), 64'h1);
    chk("sync_out_inc", 64'(inc_out), 64'h10);
    chk("sync_out_sum", 64'(sum_out), 64'h80);

    // Gapped valid every third cycle, then enable drop mid-window
    step(1'b0, 1'b0, 1'b0, 32'h0, 5'd1);
    chk("gap_idle_busy", 64'(busy), 64'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'd1);
    for (int c = 0; c < 17; c++) begin
      step(1'b1, 1'b0, (c % 3 == 0), 32'h500 + 32'(c / 3) * 32'h20, 5'd1);
      chk($sformatf("gap%0d_vld", c), 64'(inc_valid), 64'((c == 8 || c == 14) ? 1 : 0));
      if (c == 8 || c == 14) begin
        chk($sformatf("gap%0d_inc", c), 64'(inc_out), 64'h20);
        chk($sformatf("gap%0d_sum", c), 64'(sum_out), 64'h40);
      end
    end
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 5'd1);
      chk($sformatf("endrop%0d_vld", c), 64'(inc_valid), 64'h0);
      chk($sformatf("endrop%0d_busy", c), 64'(busy), 64'h0);
      chk($sformatf("endrop%0d_inc", c), 64'(inc_out), 64'h20);
      chk($sformatf("endrop%0d_sum", c), 64'(sum_out), 64'h40);
    end

    // Async reset between the completing sample and its output
    step(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
    step(1'b1, 1'b0, 1'b1, 32'h100, 5'd0);
    step(1'b1, 1'b0, 1'b1, 32'h105, 5'd0);
    chk("prerst_inc", 64'(inc_out), 64'h20);
    phase_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_inc", 64'(inc_out), 64'h0);
    chk("arst_sum", 64'(sum_out), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_vld", 64'(inc_valid), 64'h0);
    repeat (2) @(posedge out_clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 5'd0);
      chk($sformatf("postrst%0d_vld", c), 64'(inc_valid), 64'h0);
      chk($sformatf("postrst%0d_inc", c), 64'(inc_out), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
